// File: rtl/color_seq_if.sv
// Control/status bundle between the top level and color_sequencer.
// The master drives hue controls; the slave returns colour and segment.
interface color_seq_if;
  logic        en_i;
  logic        dir_i;
  logic        timeout_i;
  logic        load_i;
  logic [10:0] hue_i;
  logic [23:0] color_o;
  logic [2:0]  seg_o;
  logic        wrap_o;

  modport master (
    output en_i, dir_i, timeout_i, load_i, hue_i,
    input  color_o, seg_o, wrap_o
  );

  modport slave (
    input  en_i, dir_i, timeout_i, load_i, hue_i,
    output color_o, seg_o, wrap_o
  );
endinterface

// File: rtl/color_sequencer.sv
// Six-segment hue wheel stepped by prescaled timeout pulses.
// Colour is mapped from next-state so it lands on the same edge as the hue.
module color_sequencer #(
  parameter logic [7:0] STEP = 8'd16,
  parameter int         DIV  = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  color_seq_if.slave   bus
);

  localparam int PW = $clog2(DIV + 1);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [2:0]    r_seg;
  logic [7:0]    r_phase;
  logic [PW-1:0] r_pre;
  logic [23:0]   r_color;
  logic          r_wrap;

  logic          w_cnt;
  logic          w_adv;
  logic [8:0]    w_sum;
  logic [8:0]    w_diff;
  logic [2:0]    w_seg;
  logic [7:0]    w_phase;
  logic [PW-1:0] w_pre;
  logic          w_wrap;

  assign w_cnt  = bus.en_i & bus.timeout_i;
  assign w_adv  = w_cnt & (r_pre == PMAX);
  assign w_sum  = {1'b0, r_phase} + {1'b0, STEP};
  assign w_diff = {1'b0, r_phase} - {1'b0, STEP};

  always_comb begin
    w_seg   = r_seg;
    w_phase = r_phase;
    w_pre   = r_pre;
    w_wrap  = 1'b0;
    if (bus.load_i) begin
      w_seg   = (bus.hue_i[10:8] > 3'd5) ? 3'd5 : bus.hue_i[10:8];
      w_phase = bus.hue_i[7:0];
      w_pre   = '0;
    end else if (w_adv) begin
      w_pre = '0;
      if (bus.dir_i) begin
        w_phase = w_diff[7:0];
        if (w_diff[8]) begin
          w_seg  = (r_seg == 3'd0) ? 3'd5 : r_seg - 3'd1;
          w_wrap = (r_seg == 3'd0);
        end
      end else begin
        w_phase = w_sum[7:0];
        if (w_sum[8]) begin
          w_seg  = (r_seg == 3'd5) ? 3'd0 : r_seg + 3'd1;
          w_wrap = (r_seg == 3'd5);
        end
      end
    end else if (w_cnt) begin
      w_pre = r_pre + PW'(1);
    end
  end

  function automatic logic [23:0] hue2rgb(
    input logic [2:0] seg,
    input logic [7:0] r
  );
    logic [7:0] nr;
    nr = 8'hFF - r;
    case (seg)
      3'd0:    hue2rgb = {8'hFF, r,     8'h00};
      3'd1:    hue2rgb = {nr,    8'hFF, 8'h00};
      3'd2:    hue2rgb = {8'h00, 8'hFF, r};
      3'd3:    hue2rgb = {8'h00, nr,    8'hFF};
      3'd4:    hue2rgb = {r,     8'h00, 8'hFF};
      default: hue2rgb = {8'hFF, 8'h00, nr};
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_seg   <= 3'd0;
      r_phase <= 8'h00;
      r_pre   <= '0;
      r_color <= 24'hFF0000;
      r_wrap  <= 1'b0;
    end else begin
      r_seg   <= w_seg;
      r_phase <= w_phase;
      r_pre   <= w_pre;
      r_color <= hue2rgb(w_seg, w_phase);
      r_wrap  <= w_wrap;
    end
  end

  assign bus.color_o = r_color;
  assign bus.seg_o   = r_seg;
  assign bus.wrap_o  = r_wrap;

endmodule

// File: tb/tb_color_sequencer.sv
// Bench for color_sequencer: three parameterisations share one stimulus stream,
// each checked against a hue-position model on the 0..1535 wheel.
module tb_color_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        dir = 1'b0;
  logic        to = 1'b0;
  logic        ld = 1'b0;
  logic [10:0] hue = '0;

  color_seq_if ifa ();
  color_seq_if ifb ();
  color_seq_if ifc ();

  assign ifa.en_i = en;  assign ifa.dir_i = dir;
  assign ifa.timeout_i = to; assign ifa.load_i = ld;
  assign ifa.hue_i = hue;
  assign ifb.en_i = en;  assign ifb.dir_i = dir;
  assign ifb.timeout_i = to; assign ifb.load_i = ld;
  assign ifb.hue_i = hue;
  assign ifc.en_i = en;  assign ifc.dir_i = dir;
  assign ifc.timeout_i = to; assign ifc.load_i = ld;
  assign ifc.hue_i = hue;

  color_sequencer #(.STEP(8'h40), .DIV(1)) u_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  color_sequencer #(.STEP(8'h40), .DIV(3)) u_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.slave));
  color_sequencer #(.STEP(8'h10), .DIV(1)) u_c (
    .clk_i(clk), .rst_i(rst), .bus(ifc.slave));

  int n_cmp = 0;
  int n_err = 0;

  int stp [3] = '{64, 64, 16};
  int dv  [3] = '{1, 3, 1};
  int pos [3];
  int pre [3];
  bit wr  [3];
  logic [23:0] prev_c;

  function automatic logic [23:0] rgb(input int p);
    int s;
    logic [7:0] r;
    s = p / 256;
    r = 8'(p % 256);
    case (s)
      0: return {8'hFF, r, 8'h00};
      1: return {8'hFF - r, 8'hFF, 8'h00};
      2: return {8'h00, 8'hFF, r};
      3: return {8'h00, 8'hFF - r, 8'hFF};
      4: return {r, 8'h00, 8'hFF};
      default: return {8'hFF, 8'h00, 8'hFF - r};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input int k);
    int s;
    int np;
    if (rst) begin
      pos[k] = 0; pre[k] = 0; wr[k] = 0;
    end else if (ld) begin
      s = (hue[10:8] > 3'd5) ? 5 : int'(hue[10:8]);
      pos[k] = s * 256 + int'(hue[7:0]);
      pre[k] = 0; wr[k] = 0;
    end else if (en && to) begin
      wr[k] = 0;
      if (pre[k] == dv[k] - 1) begin
        pre[k] = 0;
        np = dir ? pos[k] - stp[k] : pos[k] + stp[k];
        if (np < 0) begin np += 1536; wr[k] = 1; end
        if (np >= 1536) begin np -= 1536; wr[k] = 1; end
        pos[k] = np;
      end else begin
        pre[k]++;
      end
    end else begin
      wr[k] = 0;
    end
  endtask

  function automatic int adiff(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? int'(x - y) : int'(y - x);
  endfunction

  task automatic cyc();
    int d;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) model(k);
    chk("a.color", 32'(ifa.color_o), 32'(rgb(pos[0])));
    chk("a.seg",   32'(ifa.seg_o),   32'(pos[0] / 256));
    chk("a.wrap",  32'(ifa.wrap_o),  32'(wr[0]));
    chk("b.color", 32'(ifb.color_o), 32'(rgb(pos[1])));
    chk("b.seg",   32'(ifb.seg_o),   32'(pos[1] / 256));
    chk("b.wrap",  32'(ifb.wrap_o),  32'(wr[1]));
    chk("c.color", 32'(ifc.color_o), 32'(rgb(pos[2])));
    chk("c.seg",   32'(ifc.seg_o),   32'(pos[2] / 256));
    chk("c.wrap",  32'(ifc.wrap_o),  32'(wr[2]));
    if (!rst && !ld) begin
      d = adiff(ifc.color_o[23:16], prev_c[23:16]);
      d = (adiff(ifc.color_o[15:8], prev_c[15:8]) > d) ?
          adiff(ifc.color_o[15:8], prev_c[15:8]) : d;
      d = (adiff(ifc.color_o[7:0], prev_c[7:0]) > d) ?
          adiff(ifc.color_o[7:0], prev_c[7:0]) : d;
      chk("c.continuity", 32'(d <= 16), 32'd1);
    end
    prev_c = ifc.color_o;
  endtask

  task automatic pulse();
    to = 1'b1; cyc();
    to = 1'b0; cyc();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin pos[k] = 0; pre[k] = 0; wr[k] = 0; end
    prev_c = 24'hFF0000;

    // T1 reset
    rst = 1'b1; cyc(); cyc();
    chk("t1.color", 32'(ifa.color_o), 32'h00FF0000);
    chk("t1.seg", 32'(ifa.seg_o), 32'd0);
    chk("t1.wrap", 32'(ifa.wrap_o), 32'd0);
    rst = 1'b0; en = 1'b1; dir = 1'b0;

    // T2 four forward pulses, plus T5 prescaled view on u_b
    to = 1'b1; cyc();
    chk("t2.p1", 32'(ifa.color_o), 32'h00FF4000);
    chk("t5.p1", 32'(ifb.color_o), 32'h00FF0000);
    to = 1'b0; cyc();
    to = 1'b1; cyc();
    chk("t2.p2", 32'(ifa.color_o), 32'h00FF8000);
    chk("t5.p2", 32'(ifb.color_o), 32'h00FF0000);
    to = 1'b0; cyc();
    to = 1'b1; cyc();
    chk("t2.p3", 32'(ifa.color_o), 32'h00FFC000);
    chk("t5.p3", 32'(ifb.color_o), 32'h00FF4000);
    to = 1'b0; cyc();
    to = 1'b1; cyc();
    chk("t2.p4", 32'(ifa.color_o), 32'h00FFFF00);
    chk("t2.seg", 32'(ifa.seg_o), 32'd1);
    chk("t2.wrap", 32'(ifa.wrap_o), 32'd0);
    to = 1'b0; cyc();

    // T3 load near the end of seg5, forward wrap
    ld = 1'b1; hue = 11'h5C0; cyc();
    ld = 1'b0;
    to = 1'b1; cyc();
    chk("t3.seg", 32'(ifa.seg_o), 32'd0);
    chk("t3.color", 32'(ifa.color_o), 32'h00FF0000);
    chk("t3.wrap", 32'(ifa.wrap_o), 32'd1);
    to = 1'b0; cyc();
    chk("t3.wrap_end", 32'(ifa.wrap_o), 32'd0);

    // T4 reverse wrap from reset
    rst = 1'b1; cyc();
    rst = 1'b0; dir = 1'b1;
    to = 1'b1; cyc();
    chk("t4.seg", 32'(ifa.seg_o), 32'd5);
    chk("t4.color", 32'(ifa.color_o), 32'h00FF003F);
    chk("t4.wrap", 32'(ifa.wrap_o), 32'd1);
    to = 1'b0; cyc();
    chk("t4.wrap_end", 32'(ifa.wrap_o), 32'd0);

    // T5 disabled pulses hold everything, including the prescaler
    dir = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) pulse();
    en = 1'b1;
    for (int i = 0; i < 3; i++) pulse();

    // T6 clamped load, then reset beating load and timeout
    ld = 1'b1; hue = 11'h7AA; cyc();
    chk("t6.seg", 32'(ifa.seg_o), 32'd5);
    chk("t6.color", 32'(ifa.color_o), 32'h00FF0055);
    rst = 1'b1; to = 1'b1; cyc();
    chk("t6.rst", 32'(ifa.color_o), 32'h00FF0000);
    rst = 1'b0; ld = 1'b0; to = 1'b0; cyc();

    // full wheel forward on u_c, timeout held high
    en = 1'b1; dir = 1'b0; to = 1'b1;
    for (int i = 0; i < 100; i++) cyc();
    to = 1'b0; cyc();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ld  = ($urandom_range(0, 39) == 0);
      en  = ($urandom_range(0, 7) != 0);
      to  = ($urandom_range(0, 2) != 0);
      dir = ($urandom_range(0, 15) == 0) ? ~dir : dir;
      hue = 11'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
